// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: show-ahead FIFO pointer/flow control in front of a dual-port RAM with 1-cycle registered read.
// Optional registered almost_full output when DPRAM_FIFO_ALMOST_FULL_EN is defined.
module dpram_fifo_ctrl #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024,
  parameter int AFULL_LEVEL = RAM_DEPTH - 4,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 ram_we_a,
  output logic [AW-1:0]        ram_addr_a,
  output logic [RAM_WIDTH-1:0] ram_din_a,
  output logic                 ram_re_b,
  output logic [AW-1:0]        ram_addr_b,
  input  logic [RAM_WIDTH-1:0] ram_dout_b,
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
  output logic                 almost_full,
`endif
  output logic [AW:0]          count
);
  localparam logic [AW:0] FULL = (AW+1)'(RAM_DEPTH);
  if (RAM_DEPTH < 2 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAM_DEPTH must be a power of two >= 2");
  end
  if (AFULL_LEVEL < 0 || AFULL_LEVEL > RAM_DEPTH + 1) begin : g_bad_afull
    $error("AFULL_LEVEL outside 0..RAM_DEPTH+1");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] mem_count;
  logic push, pop;
  // mem_count only includes words already written, so a pop never reads the address written this cycle
  always_comb begin
    s_ready = (mem_count != FULL) && !rst;
    push = s_valid && s_ready;
    pop = (!m_valid || m_ready) && (mem_count != '0) && !rst;
    ram_we_a = push;
    ram_addr_a = wr_ptr;
    ram_din_a = s_data;
    ram_re_b = pop;
    ram_addr_b = rd_ptr;
    m_data = ram_dout_b;
    count = mem_count + (AW+1)'(m_valid);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_count <= '0;
      m_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      mem_count <= mem_count + (AW+1)'(push) - (AW+1)'(pop);
      m_valid <= pop || (m_valid && !m_ready);
    end
  end
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AFULL = (AW+1)'(AFULL_LEVEL);
  always_ff @(posedge clk) almost_full <= rst ? 1'b0 : (count >= AFULL);
`endif
endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Pointer and flow-control stage that sits directly in front of the dual-port block RAM and turns it into a show-ahead FIFO. It accepts a valid/ready write stream and drives the RAM write port (A) with address, data and enable. It drives the RAM read port (B) so that the RAM's registered output appears as a valid/ready read stream. It does not contain the RAM; it connects to the RAM's ports one-for-one.

## Interface
- RAM_WIDTH, 16, data word width; must match the attached RAM
- RAM_DEPTH, 1024, RAM word count; power of two, ≥ 2; AW = $clog2(RAM_DEPTH)
- AFULL_LEVEL, RAM_DEPTH-4, almost-full threshold on `count`; used only when DPRAM_FIFO_ALMOST_FULL_EN is defined
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- s_data  in  RAM_WIDTH  write-stream data
- s_valid  in  1  write-stream valid
- s_ready  out  1  write-stream ready
- m_data  out  RAM_WIDTH  read-stream data; wired straight from ram_dout_b
- m_valid  out  1  read-stream valid
- m_ready  in  1  read-stream ready
- ram_we_a  out  1  to RAM write_enable_A
- ram_addr_a  out  AW  to RAM address_A (write pointer)
- ram_din_a  out  RAM_WIDTH  to RAM data_in_A (= s_data)
- ram_re_b  out  1  to RAM read_enable_B
- ram_addr_b  out  AW  to RAM address_B (read pointer)
- ram_dout_b  in  RAM_WIDTH  from RAM data_out_B (1-cycle registered read; holds its value while read_enable_B is low)
- count  out  AW+1  total words held (RAM plus output word)
- almost_full  out  1  present only with DPRAM_FIFO_ALMOST_FULL_EN

## Operation
**State**
- wr_ptr, rd_ptr: AW bits each; wrap modulo RAM_DEPTH by natural overflow.
- mem_count: AW+1 bits; counts words written to the RAM and not yet read out.
- m_valid: register.

**Write path**
- s_ready = (mem_count != RAM_DEPTH) && !rst.
- push = s_valid && s_ready.
- ram_we_a = push; ram_addr_a = wr_ptr; ram_din_a = s_data.
- wr_ptr increments on push.

**Read path**
- pop = (!m_valid || m_ready) && (mem_count != 0) && !rst.
- ram_re_b = pop; ram_addr_b = rd_ptr.
- rd_ptr increments on pop.

**Output register**
- Next m_valid = pop ? 1 : (m_ready ? 0 : m_valid).
- m_data is stable whenever m_valid && !m_ready, because the RAM holds its output while ram_re_b is low.

**Counters**
- mem_count next = mem_count + push − pop. A simultaneous push and pop leaves it unchanged.
- count = mem_count + m_valid. Total capacity is RAM_DEPTH + 1 words.

**Hazard avoidance**
- A word is counted in mem_count only after the edge that writes it, so a read never targets an address being written in the same cycle.

**Reset**
- rst high at a posedge clears wr_ptr, rd_ptr, mem_count and m_valid to 0, whatever transfers are in flight.
- Words held before reset are discarded; RAM contents are not cleared.
- While rst is high, s_ready, ram_we_a and ram_re_b are forced to 0.

## Timing
**Reset values**
- m_valid=0, s_ready=0 during rst and 1 after; count=0; ram_we_a=0; ram_re_b=0; ram_addr_a=ram_addr_b=0; almost_full=0.
- m_data is undefined until the first m_valid.

**Latency**
- A word accepted at edge N is written to the RAM at edge N.
- ram_re_b rises in cycle N+1, and m_valid is high in cycle N+2. Accept-to-valid latency is 2 cycles.

**Throughput**
- One push and one pop per cycle are sustained with m_ready held high.

**Handshake rules**
- s_ready depends only on registered state, never on s_valid.
- m_valid, once high, stays high until m_ready is sampled high.

**Full condition**
- s_ready drops the cycle after mem_count reaches RAM_DEPTH.
- A pop in that cycle does not raise s_ready until the following cycle.

**Empty condition**
- mem_count=0 with m_ready=1 drops m_valid on the next edge.
- An m_ready pulse on an empty FIFO has no effect.

**Wrap-around**
- Pointers roll from RAM_DEPTH−1 to 0 with no bubble.

## Configuration
- **DPRAM_FIFO_ALMOST_FULL_EN defined:**
  - adds the registered output almost_full;
  - almost_full is high on the cycle after count reaches ≥ AFULL_LEVEL, and low on the cycle after count drops below it;
  - reset value is 0.
- **DPRAM_FIFO_ALMOST_FULL_EN undefined:**
  - the almost_full port and its logic are absent;
  - AFULL_LEVEL is ignored;
  - all other behaviour is identical.

## Test plan
- **Reset then single word:** reset, then push 0xA5A5 with m_ready=0 → m_valid rises 2 cycles after accept; m_data=0xA5A5; count=1; m_data holds until m_ready.
- **Fill to capacity:** with m_ready=0, push 1..1025 → s_ready low after the 1025th accept; count=1025; m_data=1. Then a single m_ready pulse → s_ready returns 1 cycle later.
- **Streaming across wrap:** m_ready=1 and s_valid=1 continuously for 3000 words with incrementing data → output order matches; no gaps after the initial 2-cycle latency; pointers wrap twice.
- **Random backpressure:** random s_valid and m_ready over 10,000 cycles → scoreboard shows no loss, duplication or reorder. count always equals accepted minus delivered and never exceeds 1025.
- **Reset mid-operation:** with count=37, assert rst for 1 cycle → next cycle count=0, m_valid=0. A new push of 0x1234 then emerges first, with no stale data.
- **Almost full (macro defined, AFULL_LEVEL=1020):** fill with m_ready=0 → almost_full=1 the cycle after count reaches 1020; it clears the cycle after count drops to 1019.
